// File: rtl/wavegen_axil_pkg.sv
// Shared constants and FSM state types for the wavegen AXI4-Lite register block.
package wavegen_axil_pkg;

    localparam int unsigned DataWidth = 32;
    localparam int unsigned RegCount  = 4;
    localparam int unsigned IdxWidth  = 2;

    localparam logic [1:0] AxiRespOkay = 2'b00;

    localparam logic [RegCount-1:0][3:0] RegOffset = {4'hC, 4'h8, 4'h4, 4'h0};

    typedef enum logic [1:0] {WrIdle, WrHaveAw, WrHaveW, WrResp} wr_state_e;
    typedef enum logic {RdIdle, RdData} rd_state_e;

endpackage

// File: rtl/wavegen_axil_regfile.sv
// Four 32-bit registers with byte-enabled write and combinational read.
module wavegen_axil_regfile
    import wavegen_axil_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               wr_en,
    input  logic [IdxWidth-1:0]                wr_idx,
    input  logic [DataWidth-1:0]               wr_data,
    input  logic [DataWidth/8-1:0]             wr_be,
    input  logic [IdxWidth-1:0]                rd_idx,
    output logic [DataWidth-1:0]               rd_data,
    output logic [RegCount-1:0][DataWidth-1:0] regs
);

    logic [RegCount-1:0] wr_sel;

    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < RegCount; i++) begin
            wr_sel[i] = wr_en && (wr_idx == RegOffset[i][3:2]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '0;
        end else begin
            for (int i = 0; i < RegCount; i++) begin
                for (int b = 0; b < DataWidth / 8; b++) begin
                    if (wr_sel[i] && wr_be[b]) begin
                        regs[i][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end
        end
    end

    assign rd_data = regs[rd_idx];

endmodule

// File: rtl/wavegen_axil_regs.sv
// AXI4-Lite slave exposing four control registers to the wavegen core.
// Define WAVEGEN_AXIL_WSTRB_EN to honour WSTRB byte strobes; otherwise full words are written.
module wavegen_axil_regs
    import wavegen_axil_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                                ACLK,
    input  logic                                ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_AWADDR,
    input  logic                                S_AXI_AWVALID,
    output logic                                S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]     S_AXI_WSTRB,
    input  logic                                S_AXI_WVALID,
    output logic                                S_AXI_WREADY,
    output logic [1:0]                          S_AXI_BRESP,
    output logic                                S_AXI_BVALID,
    input  logic                                S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_ARADDR,
    input  logic                                S_AXI_ARVALID,
    output logic                                S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_RDATA,
    output logic [1:0]                          S_AXI_RRESP,
    output logic                                S_AXI_RVALID,
    input  logic                                S_AXI_RREADY,
    output logic [RegCount-1:0][DataWidth-1:0]  reg_out,
    output logic [RegCount-1:0]                 reg_wr
);

    wr_state_e wr_state_q, wr_state_d;
    rd_state_e rd_state_q, rd_state_d;

    logic                 aw_ready, w_ready, ar_ready;
    logic                 aw_fire, w_fire, ar_fire;
    logic                 commit;
    logic [IdxWidth-1:0]  aw_idx_q, wr_idx, rd_idx;
    logic [DataWidth-1:0] wdata_q, wr_data, rd_word, rdata_q;
    logic [3:0]           wr_be;
    logic [RegCount-1:0]  reg_wr_q;

    // Write FSM; commit marks the edge that enters WrResp, which is when the register updates.
    always_comb begin
        wr_state_d = wr_state_q;
        aw_ready   = 1'b0;
        w_ready    = 1'b0;
        commit     = 1'b0;
        unique case (wr_state_q)
            WrIdle: begin
                aw_ready = 1'b1;
                w_ready  = 1'b1;
                if (S_AXI_AWVALID && S_AXI_WVALID) begin
                    wr_state_d = WrResp;
                    commit     = 1'b1;
                end else if (S_AXI_AWVALID) begin
                    wr_state_d = WrHaveAw;
                end else if (S_AXI_WVALID) begin
                    wr_state_d = WrHaveW;
                end
            end
            WrHaveAw: begin
                w_ready = 1'b1;
                if (S_AXI_WVALID) begin
                    wr_state_d = WrResp;
                    commit     = 1'b1;
                end
            end
            WrHaveW: begin
                aw_ready = 1'b1;
                if (S_AXI_AWVALID) begin
                    wr_state_d = WrResp;
                    commit     = 1'b1;
                end
            end
            WrResp: begin
                if (S_AXI_BREADY) begin
                    wr_state_d = WrIdle;
                end
            end
        endcase
        if (ARESET) begin
            aw_ready   = 1'b0;
            w_ready    = 1'b0;
            commit     = 1'b0;
            wr_state_d = WrIdle;
        end
    end

    assign aw_fire = aw_ready && S_AXI_AWVALID;
    assign w_fire  = w_ready && S_AXI_WVALID;

    assign wr_idx  = (wr_state_q == WrHaveAw) ? aw_idx_q : S_AXI_AWADDR[IdxWidth+1:2];
    assign wr_data = (wr_state_q == WrHaveW) ? wdata_q : S_AXI_WDATA;

`ifdef WAVEGEN_AXIL_WSTRB_EN
    logic [3:0] wstrb_q;
    logic       unused_addr;

    assign wr_be       = (wr_state_q == WrHaveW) ? wstrb_q : S_AXI_WSTRB;
    assign unused_addr = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wstrb_q <= '0;
        end else if (w_fire) begin
            wstrb_q <= S_AXI_WSTRB;
        end
    end
`else
    logic unused_in;

    assign wr_be     = '1;
    assign unused_in = ^{S_AXI_WSTRB, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
`endif

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state_q <= WrIdle;
            aw_idx_q   <= '0;
            wdata_q    <= '0;
            reg_wr_q   <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            if (aw_fire) begin
                aw_idx_q <= S_AXI_AWADDR[IdxWidth+1:2];
            end
            if (w_fire) begin
                wdata_q <= S_AXI_WDATA;
            end
            reg_wr_q <= '0;
            if (commit) begin
                reg_wr_q[wr_idx] <= 1'b1;
            end
        end
    end

    // Read FSM; RDATA is sampled from the pre-edge register value, so a same-edge write is not seen.
    always_comb begin
        rd_state_d = rd_state_q;
        unique case (rd_state_q)
            RdIdle: if (S_AXI_ARVALID) rd_state_d = RdData;
            RdData: if (S_AXI_RREADY) rd_state_d = RdIdle;
        endcase
        if (ARESET) begin
            rd_state_d = RdIdle;
        end
    end

    assign ar_ready = (rd_state_q == RdIdle) && !ARESET;
    assign ar_fire  = ar_ready && S_AXI_ARVALID;
    assign rd_idx   = S_AXI_ARADDR[IdxWidth+1:2];

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_state_q <= RdIdle;
            rdata_q    <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            if (ar_fire) begin
                rdata_q <= rd_word;
            end
        end
    end

    wavegen_axil_regfile u_regfile (
        .clk     (ACLK),
        .rst     (ARESET),
        .wr_en   (commit),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .wr_be   (wr_be),
        .rd_idx  (rd_idx),
        .rd_data (rd_word),
        .regs    (reg_out)
    );

    assign S_AXI_AWREADY = aw_ready;
    assign S_AXI_WREADY  = w_ready;
    assign S_AXI_BVALID  = (wr_state_q == WrResp);
    assign S_AXI_BRESP   = AxiRespOkay;
    assign S_AXI_ARREADY = ar_ready;
    assign S_AXI_RVALID  = (rd_state_q == RdData);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = AxiRespOkay;
    assign reg_wr        = reg_wr_q;

endmodule

// File: tb/tb_wavegen_axil_regs.sv
// Directed self-checking bench for wavegen_axil_regs.
module tb_wavegen_axil_regs;

    logic              aclk = 1'b0;
    logic              areset = 1'b1;
    logic [3:0]        awaddr = '0;
    logic              awvalid = 1'b0;
    logic              awready;
    logic [31:0]       wdata = '0;
    logic [3:0]        wstrb = 4'hF;
    logic              wvalid = 1'b0;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready = 1'b0;
    logic [3:0]        araddr = '0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready = 1'b0;
    logic [3:0][31:0]  reg_out;
    logic [3:0]        reg_wr;

    int errors = 0;
    int checks = 0;
    int wr_cnt [4] = '{0, 0, 0, 0};

    always #5 aclk = ~aclk;

    wavegen_axil_regs dut (
        .ACLK          (aclk),
        .ARESET        (areset),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .reg_out       (reg_out),
        .reg_wr        (reg_wr)
    );

    always @(negedge aclk) begin
        for (int i = 0; i < 4; i++) begin
            if (reg_wr[i]) wr_cnt[i]++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
        logic aw_done = 1'b0;
        logic w_done = 1'b0;
        logic aw_hs, w_hs, b_seen;
        int t = 0;
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        while (!(aw_done && w_done) && t < 20) begin
            @(negedge aclk);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick();
            if (aw_hs) begin aw_done = 1'b1; awvalid = 1'b0; end
            if (w_hs) begin w_done = 1'b1; wvalid = 1'b0; end
            t++;
        end
        check("wr_addr_data_hs", {31'b0, aw_done && w_done}, 32'd1);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b1;
        b_seen  = 1'b0;
        t = 0;
        while (!b_seen && t < 20) begin
            @(negedge aclk);
            b_seen = bvalid;
            if (b_seen) check("bresp", {30'b0, bresp}, 32'd0);
            tick();
            t++;
        end
        check("b_hs", {31'b0, b_seen}, 32'd1);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        logic done = 1'b0;
        int t = 0;
        data    = 32'hxxxxxxxx;
        resp    = 2'bxx;
        araddr  = addr;
        arvalid = 1'b1;
        while (!done && t < 20) begin
            @(negedge aclk);
            done = arready;
            tick();
            t++;
        end
        arvalid = 1'b0;
        rready  = 1'b1;
        done    = 1'b0;
        t = 0;
        while (!done && t < 20) begin
            @(negedge aclk);
            done = rvalid;
            data = rdata;
            resp = rresp;
            tick();
            t++;
        end
        check("r_hs", {31'b0, done}, 32'd1);
        rready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        logic [31:0] exp_vals [4];
        exp_vals = '{32'd1, 32'd2, 32'd3, 32'd4};

        // Reset state
        repeat (3) tick();
        @(negedge aclk);
        check("rst_awready", {31'b0, awready}, 32'd0);
        check("rst_wready", {31'b0, wready}, 32'd0);
        check("rst_arready", {31'b0, arready}, 32'd0);
        check("rst_bvalid", {31'b0, bvalid}, 32'd0);
        check("rst_rvalid", {31'b0, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_reg_out0", reg_out[0], 32'd0);
        check("rst_reg_wr", {28'b0, reg_wr}, 32'd0);
        tick();
        areset = 1'b0;
        @(negedge aclk);
        check("post_rst_awready", {31'b0, awready}, 32'd1);
        check("post_rst_arready", {31'b0, arready}, 32'd1);
        tick();

        // Basic write/read-back of all four registers
        for (int i = 0; i < 4; i++) axi_write(4'(4 * i), exp_vals[i], 4'hF);
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(4 * i), d, r);
            check($sformatf("rd_reg%0d", i), d, exp_vals[i]);
            check($sformatf("rresp%0d", i), {30'b0, r}, 32'd0);
            check($sformatf("reg_out%0d", i), reg_out[i], exp_vals[i]);
            check($sformatf("wr_pulses%0d", i), wr_cnt[i], 32'd1);
        end

        // W three cycles ahead of AW
        wdata  = 32'hA5A5A5A5;
        wvalid = 1'b1;
        @(negedge aclk);
        check("early_w_wready", {31'b0, wready}, 32'd1);
        tick();
        wvalid = 1'b0;
        @(negedge aclk);
        check("have_w_awready", {31'b0, awready}, 32'd1);
        check("have_w_wready", {31'b0, wready}, 32'd0);
        tick();
        tick();
        awaddr  = 4'h8;
        awvalid = 1'b1;
        @(negedge aclk);
        check("late_aw_bvalid_pre", {31'b0, bvalid}, 32'd0);
        tick();
        awvalid = 1'b0;
        @(negedge aclk);
        check("late_aw_bvalid", {31'b0, bvalid}, 32'd1);
        check("late_aw_reg2", reg_out[2], 32'hA5A5A5A5);
        check("late_aw_reg_wr", {28'b0, reg_wr}, 32'h4);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        tick();
        check("late_aw_pulses2", wr_cnt[2], 32'd2);

        // BREADY stalled five cycles with a second AW pending
        awaddr  = 4'hC;
        wdata   = 32'h55;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        tick();
        awvalid = 1'b1;
        awaddr  = 4'h4;
        wvalid  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check("stall_bvalid", {31'b0, bvalid}, 32'd1);
            check("stall_awready", {31'b0, awready}, 32'd0);
            check("stall_wready", {31'b0, wready}, 32'd0);
            tick();
        end
        bready = 1'b1;
        @(negedge aclk);
        check("b_hs_awready", {31'b0, awready}, 32'd0);
        tick();
        bready = 1'b0;
        @(negedge aclk);
        check("after_b_awready", {31'b0, awready}, 32'd1);
        tick();
        awvalid = 1'b0;
        wdata   = 32'h66;
        wvalid  = 1'b1;
        @(negedge aclk);
        check("have_aw_wready", {31'b0, wready}, 32'd1);
        check("have_aw_awready", {31'b0, awready}, 32'd0);
        tick();
        wvalid = 1'b0;
        @(negedge aclk);
        check("second_bvalid", {31'b0, bvalid}, 32'd1);
        check("second_reg1", reg_out[1], 32'h66);
        check("first_reg3", reg_out[3], 32'h55);
        bready = 1'b1;
        tick();
        bready = 1'b0;

        // RREADY stalled while a write to the same register completes
        araddr  = 4'h0;
        arvalid = 1'b1;
        @(negedge aclk);
        check("rd_stall_arready", {31'b0, arready}, 32'd1);
        tick();
        arvalid = 1'b0;
        axi_write(4'h0, 32'hDEADBEEF, 4'hF);
        for (int i = 0; i < 2; i++) begin
            @(negedge aclk);
            check("rd_stall_rvalid", {31'b0, rvalid}, 32'd1);
            check("rd_stall_rdata", rdata, 32'd1);
            tick();
        end
        check("rd_stall_reg0", reg_out[0], 32'hDEADBEEF);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        @(negedge aclk);
        check("rd_stall_done", {31'b0, rvalid}, 32'd0);
        tick();

        // Byte strobes
        axi_write(4'h0, 32'h11223344, 4'hF);
        axi_write(4'h0, 32'hFFFFFFFF, 4'b0011);
        axi_read(4'h0, d, r);
`ifdef WAVEGEN_AXIL_WSTRB_EN
        check("wstrb_partial", d, 32'h1122FFFF);
        d = wr_cnt[0];
        axi_write(4'h0, 32'h0, 4'b0000);
        check("wstrb_zero_val", reg_out[0], 32'h1122FFFF);
        check("wstrb_zero_pulse", wr_cnt[0], d + 32'd1);
`else
        check("wstrb_ignored", d, 32'hFFFFFFFF);
`endif

        // Reset between AW and W aborts the write
        awaddr  = 4'h4;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        areset  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge aclk);
            check("abort_bvalid", {31'b0, bvalid}, 32'd0);
            check("abort_awready", {31'b0, awready}, 32'd0);
            tick();
        end
        areset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            check("abort_no_b", {31'b0, bvalid}, 32'd0);
            check("abort_wready", {31'b0, wready}, 32'd1);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(4 * i), d, r);
            check($sformatf("abort_rd%0d", i), d, 32'd0);
            check($sformatf("abort_reg_out%0d", i), reg_out[i], 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wavegen_axil_regs.md
WAVEGEN_AXIL_REGS -- requirements
Module: wavegen_axil_regs

Interface
REQ-001 C_S_AXI_DATA_WIDTH, 32, AXI4-Lite data width; only 32 is supported.
REQ-002 C_S_AXI_ADDR_WIDTH, 4, byte address width covering four 32-bit registers.
REQ-003 ACLK  in  1  sole clock; all logic on rising edge.
REQ-004 ARESET  in  1  synchronous, active-high reset.
REQ-005 S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
REQ-006 S_AXI_AWVALID  in  1  write address valid.
REQ-007 S_AXI_AWREADY  out  1  write address accepted.
REQ-008 S_AXI_WDATA  in  32  write data.
REQ-009 S_AXI_WSTRB  in  4  byte strobes.
REQ-010 S_AXI_WVALID  in  1  write data valid.
REQ-011 S_AXI_WREADY  out  1  write data accepted.
REQ-012 S_AXI_BRESP  out  2  write response; always 2'b00 (OKAY).
REQ-013 S_AXI_BVALID  out  1  write response valid.
REQ-014 S_AXI_BREADY  in  1  master accepts response.
REQ-015 S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
REQ-016 S_AXI_ARVALID  in  1  read address valid.
REQ-017 S_AXI_ARREADY  out  1  read address accepted.
REQ-018 S_AXI_RDATA  out  32  read data.
REQ-019 S_AXI_RRESP  out  2  read response; always 2'b00.
REQ-020 S_AXI_RVALID  out  1  read data valid.
REQ-021 S_AXI_RREADY  in  1  master accepts read data.
REQ-022 reg_out  out  4x32  packed register contents to the wavegen core; reg_out[i] is the register at byte offset 4*i.
REQ-023 reg_wr  out  4  one-cycle pulse per register, asserted in the cycle after that register is updated.

Function
REQ-024 Register index = ADDR[3:2]; ADDR[1:0] ignored; every address maps to a register, so no error responses.
REQ-025 Write FSM states: IDLE, HAVE_AW, HAVE_W, RESP.
- IDLE: AWREADY=1, WREADY=1.
- AW alone -> HAVE_AW; W alone -> HAVE_W; both in the same cycle -> RESP.
REQ-026 HAVE_AW holds AWREADY=0, WREADY=1; HAVE_W holds AWREADY=1, WREADY=0; the missing handshake -> RESP.
REQ-027 On entry to RESP: the register is written and BVALID rises in the same cycle. AWREADY=WREADY=0 while in RESP.
REQ-028 BVALID holds until BREADY=1, then returns to IDLE; a new AW/W is accepted no earlier than the following cycle.
REQ-029 Read FSM states: IDLE (ARREADY=1, RVALID=0) and DATA (ARREADY=0, RVALID=1).
- AR handshake captures RDATA from the register value at that edge, before any write committing in the same edge, and enters DATA.
- RDATA/RRESP stay stable until RREADY=1, then return to IDLE.
REQ-030 Read and write FSMs are independent; concurrent traffic to the same register is legal.

Reset
REQ-031 While ARESET=1: all registers 0, reg_wr=0, all READY/VALID low, BRESP/RRESP/RDATA 0, both FSMs IDLE. Reset asserted mid-transaction aborts it with no register write and no response. READY signals rise in the first cycle after reset deasserts.

Configuration
REQ-032 WAVEGEN_AXIL_WSTRB_EN defined: only bytes with WSTRB[k]=1 are updated, and reg_wr pulses even when WSTRB=0. Undefined: WSTRB is ignored and the full word is written.

Structure
REQ-033 Package wavegen_axil_pkg holds the AXI response codes, register offset constants (0x0, 0x4, 0x8, 0xC), register count, and the FSM state enums. One natural sub-module is wavegen_axil_regfile: strobed write, combinational read.

Verification
REQ-034 Write 1,2,3,4 to 0x0/0x4/0x8/0xC, then read back -> RDATA 1,2,3,4 with RRESP=0; reg_out matches; each reg_wr bit pulses once.
REQ-035 W (0xA5A5A5A5) presented 3 cycles before AW (0x8) -> a single write, BVALID 1 cycle after the AW handshake, reg_out[2]=0xA5A5A5A5.
REQ-036 BREADY held low for 5 cycles -> BVALID stays high, AWREADY=WREADY=0, and a pending second AW is not accepted until after the B handshake.
REQ-037 RREADY held low for 4 cycles while a write to the same register completes -> RDATA keeps the pre-write value.
REQ-038 With WAVEGEN_AXIL_WSTRB_EN: reg 0x0 holds 0x11223344; write 0xFFFFFFFF with WSTRB=4'b0011 -> reads back 0x1122FFFF.
REQ-039 ARESET pulsed after the AW handshake but before W -> no register change, no BVALID, and all registers read 0.
